// File: rtl/run_controller.sv
// run_controller: turns debounced step/run buttons and mode switches into the
// one-cycle step_pulse clock enable that advances the processor. Supports
// manual single-step, free run, run-N-cycles and run-to-breakpoint.
module run_controller #(
   parameter int PRESCALE = 50000000,
   parameter int CNT_W    = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             step_btn,
   input  logic             run_btn,
   input  logic [1:0]       mode_sel,
   input  logic [CNT_W-1:0] run_count,
   input  logic             bp_enable,
   input  logic [32:0]      bp_addr,
   input  logic [32:0]      pc,
   output logic             step_pulse,
   output logic             running,
   output logic             halted_bp,
   output logic [CNT_W-1:0] steps_left,
   output logic [1:0]       state
);

   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      HALT = 2'b10
   } state_t;

   localparam logic [1:0] MODE_MANUAL = 2'b00;
   localparam logic [1:0] MODE_RUN_N  = 2'b10;
   localparam logic [1:0] MODE_BP     = 2'b11;

   // Button conditioning: two-flop synchronizer, previous-value flop, registered edge
   logic step_meta_q, step_sync_q, step_prev_q, step_evt_q;
   logic run_meta_q,  run_sync_q,  run_prev_q,  run_evt_q;

   // Control state
   state_t           state_q, state_d;
   logic [1:0]       run_mode_q, run_mode_d;
   logic [PS_W-1:0]  presc_q, presc_d;
   logic [CNT_W-1:0] steps_q, steps_d;
   logic             pulse_q, pulse_d;
   logic             skip_q, skip_d;   // skip breakpoint compare on first tick after resume
   logic             tick;
   logic             bp_hit;

   // Synchronize the asynchronous buttons and detect their rising edges
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         step_meta_q <= 1'b0;
         step_sync_q <= 1'b0;
         step_prev_q <= 1'b0;
         step_evt_q  <= 1'b0;
         run_meta_q  <= 1'b0;
         run_sync_q  <= 1'b0;
         run_prev_q  <= 1'b0;
         run_evt_q   <= 1'b0;
      end else begin
         step_meta_q <= step_btn;
         step_sync_q <= step_meta_q;
         step_prev_q <= step_sync_q;
         step_evt_q  <= step_sync_q & ~step_prev_q;
         run_meta_q  <= run_btn;
         run_sync_q  <= run_meta_q;
         run_prev_q  <= run_sync_q;
         run_evt_q   <= run_sync_q & ~run_prev_q;
      end
   end

   assign tick   = (state_q == RUN) && (presc_q == PS_LAST);
   assign bp_hit = bp_enable && !skip_q && (pc == bp_addr);

   // State register plus the counters and pulse that move with it
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         run_mode_q <= MODE_MANUAL;
         presc_q    <= '0;
         steps_q    <= '0;
         pulse_q    <= 1'b0;
         skip_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         run_mode_q <= run_mode_d;
         presc_q    <= presc_d;
         steps_q    <= steps_d;
         pulse_q    <= pulse_d;
         skip_q     <= skip_d;
      end
   end

   // Next-state logic: button events and prescaler ticks drive the transitions
   always_comb begin
      state_d    = state_q;
      run_mode_d = run_mode_q;
      presc_d    = presc_q;
      steps_d    = steps_q;
      pulse_d    = 1'b0;
      skip_d     = skip_q;
      case (state_q)
         IDLE: begin
            presc_d = '0;
            if (run_evt_q && (mode_sel != MODE_MANUAL)) begin
               // A run start always takes priority over a simultaneous step
               if (mode_sel == MODE_RUN_N) begin
                  steps_d = run_count;
                  if (run_count != '0) begin
                     state_d    = RUN;
                     run_mode_d = mode_sel;
                     skip_d     = 1'b0;
                  end
               end else begin
                  state_d    = RUN;
                  run_mode_d = mode_sel;
                  skip_d     = 1'b0;
               end
            end else if (step_evt_q) begin
               pulse_d = 1'b1;
            end
         end
         RUN: begin
            if (run_evt_q) begin
               // Stop wins over a coincident tick; steps_left keeps its value
               state_d = IDLE;
               presc_d = '0;
            end else if (tick) begin
               presc_d = '0;
               skip_d  = 1'b0;
               case (run_mode_q)
                  MODE_RUN_N: begin
                     pulse_d = 1'b1;
                     steps_d = steps_q - CNT_W'(1);
                     if (steps_q == CNT_W'(1)) begin
                        state_d = IDLE;
                     end
                  end
                  MODE_BP: begin
                     if (bp_hit) begin
                        state_d = HALT;
                     end else begin
                        pulse_d = 1'b1;
                     end
                  end
                  default: pulse_d = 1'b1;
               endcase
            end else begin
               presc_d = presc_q + PS_W'(1);
            end
         end
         HALT: begin
            presc_d = '0;
            if (run_evt_q) begin
               state_d = RUN;
               skip_d  = 1'b1;
            end else if (step_evt_q) begin
               pulse_d = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            presc_d = '0;
         end
      endcase
   end

   // Outputs decoded from the registered state
   always_comb begin
      step_pulse = pulse_q;
      running    = (state_q == RUN);
      halted_bp  = (state_q == HALT);
      steps_left = steps_q;
      state      = state_q;
   end

endmodule

// File: tb/tb_run_controller.sv
// tb_run_controller: directed stimulus for run_controller with an event-level
// reference model checked every cycle plus hand-computed literal expectations.
module tb_run_controller;

   localparam int P  = 4;
   localparam int CW = 16;

   logic          clock;
   logic          reset;
   logic          step_btn;
   logic          run_btn;
   logic [1:0]    mode_sel;
   logic [CW-1:0] run_count;
   logic          bp_enable;
   logic [32:0]   bp_addr;
   logic [32:0]   pc;
   logic          step_pulse;
   logic          running;
   logic          halted_bp;
   logic [CW-1:0] steps_left;
   logic [1:0]    state;

   logic          pc_load;
   logic [32:0]   pc_init;

   int checks   = 0;
   int failures = 0;

   run_controller #(.PRESCALE(P), .CNT_W(CW)) dut (
      .clock(clock), .reset(reset), .step_btn(step_btn), .run_btn(run_btn),
      .mode_sel(mode_sel), .run_count(run_count), .bp_enable(bp_enable),
      .bp_addr(bp_addr), .pc(pc), .step_pulse(step_pulse), .running(running),
      .halted_bp(halted_bp), .steps_left(steps_left), .state(state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Emulated program counter: advances once per processor step
   always @(negedge clock) begin
      if (pc_load) pc = pc_init;
      else if (step_pulse === 1'b1) pc = pc + 33'd1;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Events are derived from the history of sampled button levels: a press first
   // sampled at edge k becomes an event during the cycle after edge k+2, so the
   // decision at edge e uses sample e-3 high and sample e-4 low. Run ticks fall
   // every P edges counted from the entry edge.
   int         m_e;
   int         m_entry;
   logic [4:0] m_hs, m_hr;
   logic [1:0] m_state;
   logic [1:0] m_mode;
   logic       m_pulse;
   logic       m_skip;
   logic [CW-1:0] m_steps;

   always @(posedge clock or posedge reset) begin
      logic sev, rev, pl;
      if (reset) begin
         m_e = 0; m_entry = 0; m_hs = '0; m_hr = '0; m_state = 2'd0;
         m_mode = 2'd0; m_pulse = 1'b0; m_skip = 1'b0; m_steps = '0;
      end else begin
         m_e++;
         m_hs = {m_hs[3:0], step_btn};
         m_hr = {m_hr[3:0], run_btn};
         sev = m_hs[3] & ~m_hs[4];
         rev = m_hr[3] & ~m_hr[4];
         pl  = 1'b0;
         if (m_state == 2'd0) begin
            if (rev && mode_sel != 2'd0) begin
               if (mode_sel == 2'd2) m_steps = run_count;
               if (mode_sel != 2'd2 || run_count != 0) begin
                  m_state = 2'd1; m_mode = mode_sel; m_entry = m_e; m_skip = 1'b0;
               end
            end else if (sev) pl = 1'b1;
         end else if (m_state == 2'd1) begin
            if (rev) m_state = 2'd0;
            else if (((m_e - m_entry) % P) == 0) begin
               if (m_mode == 2'd2) begin
                  pl = 1'b1;
                  m_steps = m_steps - 1;
                  if (m_steps == 0) m_state = 2'd0;
               end else if (m_mode == 2'd3 && bp_enable && !m_skip && pc == bp_addr) begin
                  m_state = 2'd2;
               end else pl = 1'b1;
               m_skip = 1'b0;
            end
         end else begin
            if (rev) begin
               m_state = 2'd1; m_entry = m_e; m_skip = 1'b1;
            end else if (sev) begin
               pl = 1'b1; m_state = 2'd0;
            end
         end
         m_pulse = pl;
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clock) begin
      chk("cyc_step_pulse", {63'd0, step_pulse}, {63'd0, m_pulse});
      chk("cyc_running",    {63'd0, running},    {63'd0, (m_state == 2'd1)});
      chk("cyc_halted_bp",  {63'd0, halted_bp},  {63'd0, (m_state == 2'd2)});
      chk("cyc_steps_left", {48'd0, steps_left}, {48'd0, m_steps});
      chk("cyc_state",      {62'd0, state},      {62'd0, m_state});
   end

   // ---------------- directed stimulus ----------------
   task automatic wait_pulse(input int maxc, output int n);
      n = -1;
      for (int i = 1; i <= maxc; i++) begin
         @(negedge clock);
         if (step_pulse === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic count_pulses(input int ncyc, output int cnt);
      cnt = 0;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clock);
         if (step_pulse === 1'b1) cnt++;
      end
   endtask

   task automatic press_run(input int hold);
      @(posedge clock); #2 run_btn = 1'b1;
      repeat (hold) @(negedge clock);
      run_btn = 1'b0;
   endtask

   initial begin
      int n, c;
      bit found;
      reset = 1'b1; step_btn = 1'b0; run_btn = 1'b0; mode_sel = 2'd0;
      run_count = '0; bp_enable = 1'b0; bp_addr = '0; pc_load = 1'b1; pc_init = '0;
      pc = '0;
      repeat (3) @(negedge clock);
      chk("rst_state", {62'd0, state}, 64'd0);
      chk("rst_pulse", {63'd0, step_pulse}, 64'd0);
      chk("rst_steps", {48'd0, steps_left}, 64'd0);
      @(posedge clock); #2 reset = 1'b0; pc_load = 1'b0;
      repeat (3) @(negedge clock);

      // Manual step: pulse after the 4th edge, i.e. at the 5th negedge
      @(posedge clock); #2 step_btn = 1'b1;
      wait_pulse(20, n);
      chk("step_latency", n, 5);
      chk("step_state", {62'd0, state}, 64'd0);
      count_pulses(15, c);
      chk("step_held_no_more", c, 0);
      step_btn = 1'b0;
      repeat (4) @(negedge clock);

      // Run N=3: entry at edge 4, pulses after edges 8, 12, 16
      mode_sel = 2'd2; run_count = 16'd3;
      @(posedge clock); #2 run_btn = 1'b1;
      wait_pulse(20, n);
      chk("runN_first", n, 9);
      chk("runN_steps2", {48'd0, steps_left}, 64'd2);
      run_btn = 1'b0;
      wait_pulse(10, n);
      chk("runN_second", n, 4);
      chk("runN_steps1", {48'd0, steps_left}, 64'd1);
      wait_pulse(10, n);
      chk("runN_third", n, 4);
      chk("runN_steps0", {48'd0, steps_left}, 64'd0);
      chk("runN_idle", {62'd0, state}, 64'd0);
      chk("runN_not_running", {63'd0, running}, 64'd0);
      count_pulses(12, c);
      chk("runN_no_extra", c, 0);

      // Run N=0: nothing happens
      run_count = 16'd0;
      press_run(2);
      count_pulses(12, c);
      chk("runN0_pulses", c, 0);
      chk("runN0_state", {62'd0, state}, 64'd0);
      chk("runN0_steps", {48'd0, steps_left}, 64'd0);

      // Run to breakpoint at 0x10 starting from pc 0x0E
      mode_sel = 2'd3; bp_enable = 1'b1; bp_addr = 33'h10;
      pc_init = 33'h0E; pc_load = 1'b1;
      repeat (2) @(negedge clock);
      #1 pc_load = 1'b0;
      press_run(3);
      count_pulses(20, c);
      chk("bp_pulses_before", c, 2);
      chk("bp_state_halt", {62'd0, state}, 64'd2);
      chk("bp_halted", {63'd0, halted_bp}, 64'd1);
      chk("bp_pc", {31'd0, pc}, 64'h10);
      press_run(3);
      wait_pulse(20, n);
      chk("bp_resume_pulse", n, 6);
      chk("bp_resume_state", {62'd0, state}, 64'd1);
      chk("bp_resume_halted", {63'd0, halted_bp}, 64'd0);
      @(negedge clock); #1;
      chk("bp_pc_past", {31'd0, pc}, 64'h11);
      press_run(2);
      count_pulses(10, c);
      chk("bp_stopped", {62'd0, state}, 64'd0);

      // Free run: mode change ignored, stop press lands on the third tick
      bp_enable = 1'b0; mode_sel = 2'd1;
      press_run(2);
      wait_pulse(20, n);
      chk("free_first_seen", {63'd0, (n > 0)}, 64'd1);
      mode_sel = 2'd2;
      wait_pulse(10, n);
      chk("free_second", n, 4);
      chk("free_still_running", {63'd0, running}, 64'd1);
      run_btn = 1'b1;
      count_pulses(20, c);
      chk("free_stop_no_pulse", c, 0);
      chk("free_stop_state", {62'd0, state}, 64'd0);
      chk("free_steps_hold", {48'd0, steps_left}, 64'd0);
      run_btn = 1'b0;
      repeat (4) @(negedge clock);

      // Reset while the prescaler holds 2
      mode_sel = 2'd1;
      press_run(2);
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (state == 2'd1) begin
            found = 1'b1;
            break;
         end
         @(negedge clock);
      end
      chk("rstrun_entered", {63'd0, found}, 64'd1);
      @(posedge clock);
      @(posedge clock); #2 reset = 1'b1;
      #1;
      chk("rstrun_state", {62'd0, state}, 64'd0);
      chk("rstrun_running", {63'd0, running}, 64'd0);
      chk("rstrun_pulse", {63'd0, step_pulse}, 64'd0);
      repeat (2) @(negedge clock);
      @(posedge clock); #2 reset = 1'b0;
      count_pulses(20, c);
      chk("rstrun_no_pulse", c, 0);
      chk("rstrun_idle", {62'd0, state}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
